truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 142 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks a 4-bit vector {a,b,c,d} through 0..15, waits
// SETTLE cycles per vector and captures three downstream outputs into
// 16-bit tables.
// Optional feature macro: SCAN_SINGLE_STEP_EN adds a 'step' input. When it is
// defined, the scanner parks in CAPTURE until step=1 before moving to the
// next vector.
module truth_table_scanner #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f1,
  input  logic        f2,
  input  logic        f3,
`ifdef SCAN_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tab_f1,
  output logic [15:0] tab_f2,
  output logic [15:0] tab_f3
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

  // Last settle-count value spent in DRIVE; unused when SETTLE is 0.
  localparam int          SETTLE_M1   = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]  SETTLE_LAST = SETTLE_M1[3:0];
  // With no settle time, DRIVE is skipped and each vector is captured directly.
  localparam state_t      ADV_STATE   = (SETTLE == 0) ? CAPTURE : DRIVE;

  state_t     state, state_nxt;
  logic [3:0] vec, vec_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       advance;
  logic       cap_en;

`ifdef SCAN_SINGLE_STEP_EN
  logic       held;

  // Marks that this vector was already captured while waiting for step.
  always_ff @(posedge clk) begin
    if (rst) held <= 1'b0;
    else     held <= (state == CAPTURE) && !step;
  end

  assign advance = step;
  assign cap_en  = (state == CAPTURE) && !held;
`else
  assign advance = 1'b1;
  assign cap_en  = (state == CAPTURE);
`endif

  // State, vector index and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      vec   <= vec_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: settle in DRIVE, sample once in CAPTURE, stop at 15.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ADV_STATE;
          vec_nxt   = 4'd0;
          cnt_nxt   = 4'd0;
        end
      end
      DRIVE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = CAPTURE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      CAPTURE: begin
        if (advance) begin
          cnt_nxt = 4'd0;
          if (vec == 4'd15) begin
            state_nxt = DONE;
          end else begin
            vec_nxt   = vec + 4'd1;
            state_nxt = ADV_STATE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state; the vector is only driven mid-scan.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    {a, b, c, d} = 4'b0000;
    case (state)
      DRIVE, CAPTURE: begin
        busy         = 1'b1;
        {a, b, c, d} = vec;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Truth-table capture: one bit per vector, overwritten in place on each scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      tab_f1 <= 16'h0000;
      tab_f2 <= 16'h0000;
      tab_f3 <= 16'h0000;
    end else if (cap_en) begin
      tab_f1[vec] <= f1;
      tab_f2[vec] <= f2;
      tab_f3[vec] <= f3;
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: SETTLE=2 and SETTLE=0 instances with tied
// logic functions; a SETTLE=1 single-step instance when SCAN_SINGLE_STEP_EN is set.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0;
  logic start2 = 1'b0;
  logic f3_force = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic a2, b2, c2, d2, busy2, done2;
  logic [15:0] t1_2, t2_2, t3_2;
  logic f1_2, f2_2, f3_2;
  logic a0, b0, c0, d0, busy0, done0;
  logic [15:0] t1_0, t2_0, t3_0;
  logic f1_0, f2_0, f3_0;

  always #5 clk = ~clk;

  // SETTLE=2: f1 = a, f2 = d, f3 = bench-controlled constant
  assign f1_2 = a2;
  assign f2_2 = d2;
  assign f3_2 = f3_force;
  // SETTLE=0: f1 = ~b & d, f2 = 1, f3 = c
  assign f1_0 = ~b0 & d0;
  assign f2_0 = 1'b1;
  assign f3_0 = c0;

  truth_table_scanner #(.SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .f1(f1_2), .f2(f2_2), .f3(f3_2),
`ifdef SCAN_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .tab_f1(t1_2), .tab_f2(t2_2), .tab_f3(t3_2));

  truth_table_scanner #(.SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .f1(f1_0), .f2(f2_0), .f3(f3_0),
`ifdef SCAN_SINGLE_STEP_EN
    .step(1'b1),
`endif
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .tab_f1(t1_0), .tab_f2(t2_0), .tab_f3(t3_0));

`ifdef SCAN_SINGLE_STEP_EN
  logic start1 = 1'b0;
  logic step1 = 1'b0;
  logic a1, b1, c1, d1, busy1, done1;
  logic [15:0] t1_1, t2_1, t3_1;
  logic f1_1, f2_1;
  assign f1_1 = a1;
  assign f2_1 = d1;

  truth_table_scanner #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .f1(f1_1), .f2(f2_1), .f3(1'b0),
    .step(step1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .tab_f1(t1_1), .tab_f2(t2_1), .tab_f3(t3_1));
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start0 = v;
    else        start2 = v;
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? done0 : done2;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 0) ? busy0 : busy2;
  endfunction

  // Pulse start, optionally re-pulse at cycle pulse_at, count cycles to done.
  // cyc counts the start-sampling edge as cycle 1.
  task automatic run_scan(input int w, input int pulse_at, output int cyc, output int bcnt);
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    cyc  = 1;
    bcnt = busy_of(w) ? 1 : 0;
    while (!done_of(w) && cyc < 400) begin
      if (cyc == pulse_at) set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      cyc++;
      if (busy_of(w)) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if ({busy2, done2, a2, b2, c2, d2} !== 6'b0) begin errors++; $display("FAIL reset_ctl2: got %b expected 000000", {busy2, done2, a2, b2, c2, d2}); end
    checks++; if ({t1_2, t2_2, t3_2} !== 48'h0) begin errors++; $display("FAIL reset_tab2: got %h expected 0", {t1_2, t2_2, t3_2}); end
    checks++; if ({busy0, done0, a0, b0, c0, d0} !== 6'b0) begin errors++; $display("FAIL reset_ctl0: got %b expected 000000", {busy0, done0, a0, b0, c0, d0}); end
    checks++; if ({t1_0, t2_0, t3_0} !== 48'h0) begin errors++; $display("FAIL reset_tab0: got %h expected 0", {t1_0, t2_0, t3_0}); end
  endtask

  task automatic test_scan_settle2;
    int cyc, bc;
    run_scan(2, 0, cyc, bc);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL s2_latency: got %0d expected 49", cyc); end
    checks++; if (bc !== 48) begin errors++; $display("FAIL s2_busy_cycles: got %0d expected 48", bc); end
    checks++; if (t1_2 !== 16'hFF00) begin errors++; $display("FAIL s2_tab_f1: got %h expected ff00", t1_2); end
    checks++; if (t2_2 !== 16'hAAAA) begin errors++; $display("FAIL s2_tab_f2: got %h expected aaaa", t2_2); end
    checks++; if (t3_2 !== 16'h0000) begin errors++; $display("FAIL s2_tab_f3: got %h expected 0000", t3_2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL s2_busy_in_done: got %b expected 0", busy2); end
    tick();
    checks++; if ({done2, busy2, a2, b2, c2, d2} !== 6'b0) begin errors++; $display("FAIL s2_idle_after_done: got %b expected 000000", {done2, busy2, a2, b2, c2, d2}); end
    checks++; if ({t1_2, t2_2, t3_2} !== {16'hFF00, 16'hAAAA, 16'h0000}) begin errors++; $display("FAIL s2_tab_hold: got %h expected ff00aaaa0000", {t1_2, t2_2, t3_2}); end
  endtask

  task automatic test_scan_settle0;
    int cyc, bc;
    run_scan(0, 0, cyc, bc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL s0_latency: got %0d expected 17", cyc); end
    checks++; if (bc !== 16) begin errors++; $display("FAIL s0_busy_cycles: got %0d expected 16", bc); end
    // ~b & d is 1 only for vectors 1, 3, 9, 11
    checks++; if (t1_0 !== 16'h0A0A) begin errors++; $display("FAIL s0_tab_f1: got %h expected 0a0a", t1_0); end
    checks++; if (t2_0 !== 16'hFFFF) begin errors++; $display("FAIL s0_tab_f2: got %h expected ffff", t2_0); end
    checks++; if (t3_0 !== 16'hCCCC) begin errors++; $display("FAIL s0_tab_f3: got %h expected cccc", t3_0); end
    tick();
    checks++; if ({done0, busy0} !== 2'b00) begin errors++; $display("FAIL s0_done_one_cycle: got %b expected 00", {done0, busy0}); end
  endtask

  task automatic test_start_while_busy;
    int cyc, bc, extra;
    run_scan(2, 10, cyc, bc);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL busy_start_latency: got %0d expected 49", cyc); end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done2 || busy2) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_relaunch: got %0d active cycles expected 0", extra); end
    checks++; if ({t1_2, t2_2, t3_2} !== {16'hFF00, 16'hAAAA, 16'h0000}) begin errors++; $display("FAIL busy_start_tabs: got %h expected ff00aaaa0000", {t1_2, t2_2, t3_2}); end
  endtask

  task automatic test_overwrite;
    int cyc, bc;
    f3_force = 1'b1;
    run_scan(2, 0, cyc, bc);
    checks++; if (t3_2 !== 16'hFFFF) begin errors++; $display("FAIL ovr_tab_f3_ones: got %h expected ffff", t3_2); end
    f3_force = 1'b0;
    tick();
    run_scan(2, 0, cyc, bc);
    checks++; if (t3_2 !== 16'h0000) begin errors++; $display("FAIL ovr_tab_f3_zeros: got %h expected 0000", t3_2); end
    checks++; if (t1_2 !== 16'hFF00) begin errors++; $display("FAIL ovr_tab_f1: got %h expected ff00", t1_2); end
    tick();
  endtask

  task automatic test_reset_mid_scan;
    int n, dn, cyc, bc;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while ({a2, b2, c2, d2} !== 4'd7 && n < 200) begin
      tick();
      n++;
    end
    checks++; if ({a2, b2, c2, d2} !== 4'd7) begin errors++; $display("FAIL mid_reach_vec7: got %0d expected 7", {a2, b2, c2, d2}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy2, done2, a2, b2, c2, d2} !== 6'b0) begin errors++; $display("FAIL mid_rst_ctl: got %b expected 000000", {busy2, done2, a2, b2, c2, d2}); end
    checks++; if ({t1_2, t2_2, t3_2} !== 48'h0) begin errors++; $display("FAIL mid_rst_tabs: got %h expected 0", {t1_2, t2_2, t3_2}); end
    dn = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done2) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d pulses expected 0", dn); end
    run_scan(2, 0, cyc, bc);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL mid_rescan_latency: got %0d expected 49", cyc); end
    checks++; if ({t1_2, t2_2, t3_2} !== {16'hFF00, 16'hAAAA, 16'h0000}) begin errors++; $display("FAIL mid_rescan_tabs: got %h expected ff00aaaa0000", {t1_2, t2_2, t3_2}); end
    tick();
  endtask

  task automatic test_back_to_back;
    int n, bad;
    start2 = 1'b1;
    n = 0;
    while (!done2 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done2); end
    n = 0;
    bad = 0;
    do begin
      tick();
      n++;
      if (t1_2 !== 16'hFF00 || t2_2 !== 16'hAAAA) bad++;
    end while (!done2 && n < 200);
    checks++; if (n !== 50) begin errors++; $display("FAIL b2b_period: got %0d expected 50", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_tab_stable: got %0d unstable cycles expected 0", bad); end
    start2 = 1'b0;
    n = 0;
    while ((busy2 || done2) && n < 200) begin
      tick();
      n++;
    end
    checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL b2b_stop: got %b expected 00", {busy2, done2}); end
  endtask

`ifdef SCAN_SINGLE_STEP_EN
  task automatic test_single_step;
    int bad;
    bad = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      repeat (4) tick();
      if ({a1, b1, c1, d1} !== i[3:0] || busy1 !== 1'b1 || done1 !== 1'b0) bad++;
      step1 = 1'b1;
      tick();
      step1 = 1'b0;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL step_vec_advance: got %0d bad steps expected 0", bad); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL step_done: got %b expected 1", done1); end
    checks++; if ({t1_1, t2_1, t3_1} !== {16'hFF00, 16'hAAAA, 16'h0000}) begin errors++; $display("FAIL step_tabs: got %h expected ff00aaaa0000", {t1_1, t2_1, t3_1}); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_scan_settle2();
    test_scan_settle0();
    test_start_while_busy();
    test_overwrite();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef SCAN_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
